// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory request/response channel and decode-stage handshake.
interface fetch_prefetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_npc;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_ir, id_npc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_ir, id_npc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: issues imem requests, buffers in-order responses in a
// DEPTH-entry queue and hands {IR, NPC} to decode; redirects flush and drop.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk1,
    input  logic                         rst_n,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    input  logic                         halt,
    fetch_prefetch_unit_if.master        bus,
    output logic [31:0]                  fetch_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   npc_q, npc_d;

    logic [31:0]   mem_ir  [DEPTH];
    logic [31:0]   mem_npc [DEPTH];

    logic          req_fire;
    logic          rsp_take;
    logic          push;
    logic          pop;
    logic [CW:0]   inflight;
    logic [CW-1:0] occ_after_pop;
    logic          unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    // Issue cap counts both buffered entries and responses still owed by memory.
    assign inflight           = {1'b0, occ_q} + {1'b0, out_q};
    assign bus.imem_req_valid = rst_n && !halt && !redirect_valid &&
                                (inflight < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = {fetch_pc_q[31:2], 2'b00};

    assign req_fire      = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_take      = bus.imem_rsp_valid && (out_q != '0);
    assign push          = rsp_take && (drop_q == '0) && !redirect_valid;
    assign pop           = bus.id_valid && bus.id_ready;
    assign occ_after_pop = occ_q - CW'(pop);

    always_comb begin
        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        out_d      = out_q + CW'(req_fire) - CW'(rsp_take);
        drop_d     = (rsp_take && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        occ_d      = occ_after_pop + CW'(push);
        head_d     = head_q + PW'(pop);
        tail_d     = tail_q + PW'(push);

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            drop_d     = out_q - CW'(rsp_take);
            occ_d      = '0;
            head_d     = '0;
            tail_d     = '0;
        end

        // Look ahead to next cycle's head so id_ir/id_npc leave straight from flops.
        ir_d  = '0;
        npc_d = '0;
        if (occ_d != '0) begin
            if (occ_after_pop == '0) begin
                ir_d  = bus.imem_rsp_data;
                npc_d = rsp_pc_q + 32'd4;
            end else begin
                ir_d  = mem_ir[head_d];
                npc_d = mem_npc[head_d];
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= {RESET_PC[31:2], 2'b00};
            occ_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            ir_q       <= '0;
            npc_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ir_q       <= ir_d;
            npc_q      <= npc_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            mem_ir[tail_q]  <= bus.imem_rsp_data;
            mem_npc[tail_q] <= rsp_pc_q + 32'd4;
        end
    end

    assign bus.id_valid = (occ_q != '0);
    assign bus.id_ir    = ir_q;
    assign bus.id_npc   = npc_q;
    assign fetch_pc     = fetch_pc_q;
    assign occupancy    = occ_q;
endmodule
